cache_block_memory: RTL and testbench

- Memory-side responder for the cache's block-level memory request/response interface.
- Accepts one block read or write from the cache controller and serves it from an internal word array after a fixed, programmable latency.
- Returns a one-cycle ack carrying the block data for reads.
- Sits between the data cache and backing storage; used as main memory in simulation and as an on-chip RAM model in synthesis.

---
 rtl/cache_block_memory.sv | 121 ++++++++++++
 tb/tb_cache_block_memory.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cache_block_memory.sv
// Block-level memory responder for the data cache.
// Serves one block read/write after a fixed latency, then a turnaround cycle.
module cache_block_memory #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32,
    parameter int BLOCK_SIZE = 2,
    parameter int MEM_BLOCKS = 512,
    parameter int LATENCY    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            mem_req_addr,
    input  logic                             mem_req_cs,
    input  logic                             mem_req_rw,
    input  logic [BLOCK_SIZE*WORD_WIDTH-1:0] mem_req_data,
    output logic                             mem_resp_ack,
    output logic [BLOCK_SIZE*WORD_WIDTH-1:0] mem_resp_data,
    output logic                             busy
);

    localparam int OFF_W = $clog2(BLOCK_SIZE);
    localparam int IDX_W = (MEM_BLOCKS > 1) ? $clog2(MEM_BLOCKS) : 1;
    localparam int BW    = BLOCK_SIZE * WORD_WIDTH;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK,
        TURN
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              rw_q, rw_d;
    logic [BW-1:0]     wdata_q, wdata_d;
    logic [BW-1:0]     rdata_q, rdata_d;
    logic [BW-1:0]     mem_q [MEM_BLOCKS];
    logic [IDX_W-1:0]  req_idx;
    logic              unused_addr;

    // Offset and upper bits are dropped: block-aligned, wraps modulo MEM_BLOCKS.
    assign req_idx     = mem_req_addr[OFF_W +: IDX_W];
    assign unused_addr = ^mem_req_addr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (mem_req_cs) begin
                    idx_d   = req_idx;
                    rw_d    = mem_req_rw;
                    wdata_d = mem_req_data;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = ACK;
                        if (!mem_req_rw) begin
                            rdata_d = mem_q[req_idx];
                        end
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ACK;
                    if (!rw_q) begin
                        rdata_d = mem_q[idx_q];
                    end
                end
            end
            ACK: begin
                state_d = TURN;
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Commit lands on the edge ending the ack cycle, before any new acceptance.
    always_ff @(posedge clk) begin
        if (!rst && state_q == ACK && rw_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign mem_resp_ack  = (state_q == ACK);
    assign mem_resp_data = rdata_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_cache_block_memory.sv
// Directed self-checking bench for cache_block_memory.
module tb_cache_block_memory;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        cs;
    logic        rw;
    logic [63:0] data;
    logic        ack;
    logic [63:0] resp_data;
    logic        busy;

    int total;
    int bad;

    cache_block_memory #(
        .ADDR_WIDTH(32),
        .WORD_WIDTH(32),
        .BLOCK_SIZE(2),
        .MEM_BLOCKS(512),
        .LATENCY(LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req_addr (addr),
        .mem_req_cs   (cs),
        .mem_req_rw   (rw),
        .mem_req_data (data),
        .mem_resp_ack (ack),
        .mem_resp_data(resp_data),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One isolated operation; mangle rewrites the request inputs during BUSY.
    task automatic op(input string tag, input logic [31:0] a, input logic w,
                      input logic [63:0] d, input bit mangle,
                      output logic [63:0] rd);
        int ackj;
        int nack;
        int nbusy;
        @(negedge clk);
        addr = a; rw = w; data = d; cs = 1'b1;
        @(posedge clk); #1;
        cs = 1'b0;
        ackj = -1; nack = 0; nbusy = 0; rd = 'x;
        for (int j = 0; j < 12; j++) begin
            if (mangle && j == 0) begin
                cs = 1'b1; addr = 32'h0000_0077; rw = 1'b1;
                data = 64'hBAD0_BAD0_BAD0_BAD0;
            end
            if (mangle && j == LAT) cs = 1'b0;
            if (ack) begin
                nack++;
                if (ackj < 0) ackj = j;
                rd = resp_data;
            end
            if (busy) nbusy++;
            @(posedge clk); #1;
        end
        check({tag, "_acks"}, 64'(nack), 64'd1);
        check({tag, "_lat"}, 64'(ackj), 64'(LAT - 1));
        check({tag, "_busy"}, 64'(nbusy), 64'(LAT + 1));
    endtask

    logic [63:0] rd;
    logic [63:0] hold;

    initial begin
        int nack;
        int nbusy;
        int a1;
        int a2;
        int nz;
        total = 0; bad = 0;
        rst = 1'b1; cs = 1'b0; rw = 1'b0; addr = '0; data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        nack = 0; nbusy = 0; nz = 0;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); #1;
            if (ack) nack++;
            if (busy) nbusy++;
            if (resp_data !== 64'h0) nz++;
        end
        check("rst_ack", 64'(nack), 64'd0);
        check("rst_busy", 64'(nbusy), 64'd0);
        check("rst_data", 64'(nz), 64'd0);

        op("wr10", 32'h10, 1'b1, {32'hDEADBEEF, 32'h12345678}, 1'b0, rd);
        op("rd11", 32'h11, 1'b0, 64'h0, 1'b0, rd);
        check("rd11_data", rd, {32'hDEADBEEF, 32'h12345678});

        op("wr0", 32'h0, 1'b1, {32'h0, 32'hAAAA_0001}, 1'b0, rd);
        hold = resp_data;
        check("wr_hold", hold, {32'hDEADBEEF, 32'h12345678});
        op("rd400", 32'h400, 1'b0, 64'h0, 1'b0, rd);
        check("wrap_data", rd, {32'h0, 32'hAAAA_0001});

        op("wr40", 32'h40, 1'b1, 64'h4040_4040_0000_0040, 1'b0, rd);
        op("wr76", 32'h76, 1'b1, 64'h7676_7676_7676_7676, 1'b0, rd);

        @(negedge clk);
        addr = 32'h20; rw = 1'b1; data = 64'h2020_2020_0000_0020; cs = 1'b1;
        @(posedge clk); #1;
        a1 = -1; a2 = -1; nack = 0;
        for (int j = 0; j < 20; j++) begin
            if (ack) begin
                nack++;
                if (a1 < 0) a1 = j;
                else if (a2 < 0) begin a2 = j; rd = resp_data; end
            end
            if (j == LAT) begin addr = 32'h40; rw = 1'b0; data = '0; end
            if (j == LAT + 2) cs = 1'b0;
            @(posedge clk); #1;
        end
        check("wbal_acks", 64'(nack), 64'd2);
        check("wbal_first", 64'(a1), 64'(LAT - 1));
        check("wbal_space", 64'(a2 - a1), 64'(LAT + 2));
        check("wbal_data", rd, 64'h4040_4040_0000_0040);
        op("rd20", 32'h20, 1'b0, 64'h0, 1'b0, rd);
        check("rd20_data", rd, 64'h2020_2020_0000_0020);

        op("wr50m", 32'h50, 1'b1, 64'h5050_5050_5050_5050, 1'b1, rd);
        op("rd50", 32'h50, 1'b0, 64'h0, 1'b0, rd);
        check("latch_data", rd, 64'h5050_5050_5050_5050);
        op("rd76", 32'h76, 1'b0, 64'h0, 1'b0, rd);
        check("latch_other", rd, 64'h7676_7676_7676_7676);

        op("wr30", 32'h30, 1'b1, 64'h3030_3030_3030_3030, 1'b0, rd);
        @(negedge clk);
        addr = 32'h30; rw = 1'b1; data = 64'h5555; cs = 1'b1;
        @(posedge clk); #1;
        cs = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        nack = 0;
        for (int j = 0; j < 10; j++) begin
            if (ack) nack++;
            @(posedge clk); #1;
        end
        check("abort_ack", 64'(nack), 64'd0);
        op("rd30", 32'h30, 1'b0, 64'h0, 1'b0, rd);
        check("abort_data", rd, 64'h3030_3030_3030_3030);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
